// File: rtl/uart_pkg.sv
// Shared types and constants for the UART oversampling receiver front end.
package uart_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } uart_state_t;

    // Vote counts the majority voter is meant to be built with (odd, 3..7).
    localparam int SAMPLES_MIN  = 3;
    localparam int SAMPLES_MAX  = 7;
    localparam int SAMPLES_STEP = 2;

endpackage

// File: rtl/uart_majority_vote.sv
// Purely combinational majority voter over an odd number of line samples.
module uart_majority_vote
    import uart_pkg::*;
#(
    parameter int SAMPLES = 3
) (
    input  logic [SAMPLES-1:0] samples,
    output logic               vote
);

    localparam int CW = $clog2(SAMPLES + 1);

    logic [CW-1:0] ones;

    always_comb begin
        ones = '0;
        for (int i = 0; i < SAMPLES; i++) begin
            ones = ones + CW'(samples[i]);
        end
        vote = (ones > CW'(SAMPLES / 2));
    end

endmodule

// File: rtl/uart_oversampler.sv
// UART bit-period counter with centred majority-vote sampling.
// Define UART_NOISE_FLAG_EN to add the noise_err output (samples disagreed).
module uart_oversampler
    import uart_pkg::*;
#(
    parameter int PRESC_W = 6,
    parameter int SAMPLES = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               RX_IN,
    input  logic               data_samp_en,
    input  logic [PRESC_W-1:0] Prescale,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic               bit_done,
    output logic               sampled_bit,
    output logic               bit_valid,
`ifdef UART_NOISE_FLAG_EN
    output logic               noise_err,
`endif
    output logic               cfg_err
);

    localparam int                 SW     = SAMPLES - 1;
    localparam logic [PRESC_W-1:0] HALF   = PRESC_W'((SAMPLES - 1) / 2);
    localparam logic [PRESC_W-1:0] PR_MIN = PRESC_W'(SAMPLES + 1);

    uart_state_t        state_q, state_d;
    logic [PRESC_W-1:0] pr_q, cnt_q;
    logic [PRESC_W-1:0] pr_last, win_lo, win_hi;
    logic [SW-1:0]      samp_q;
    logic [SAMPLES-1:0] vote_vec;
    logic               pr_ok, running, in_win, vote_ld, vote;

    assign pr_last = pr_q - PRESC_W'(1);
    assign win_lo  = (pr_q >> 1) - HALF;
    assign win_hi  = (pr_q >> 1) + HALF;
    assign pr_ok   = (pr_q >= PR_MIN) && !pr_q[0];
    assign in_win  = (cnt_q >= win_lo) && (cnt_q <= win_hi);
    assign vote_ld = running && pr_ok && (cnt_q == win_hi);

    // The last sample is taken straight from the line so the vote lands one clk after it.
    assign vote_vec = {samp_q, RX_IN};
    assign edge_cnt = cnt_q;

    uart_majority_vote #(.SAMPLES(SAMPLES)) u_vote (
        .samples (vote_vec),
        .vote    (vote)
    );

    always_comb begin
        state_d  = state_q;
        running  = 1'b0;
        bit_done = 1'b0;
        cfg_err  = 1'b0;
        case (state_q)
            IDLE: if (data_samp_en) state_d = RUN;
            RUN: begin
                bit_done = (cnt_q == pr_last);
                cfg_err  = !pr_ok;
                if (data_samp_en) running = 1'b1;
                else              state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                             pr_q <= '0;
        else if (state_q == IDLE && data_samp_en) pr_q <= Prescale;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         cnt_q <= '0;
        else if (running) cnt_q <= (cnt_q == pr_last) ? '0 : cnt_q + PRESC_W'(1);
        else              cnt_q <= '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                         samp_q <= '0;
        else if (!running || cnt_q == '0) samp_q <= '0;
        else if (pr_ok && in_win)         samp_q <= {samp_q[SW-2:0], RX_IN};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sampled_bit <= 1'b1;
            bit_valid   <= 1'b0;
        end else begin
            bit_valid <= vote_ld;
            if (vote_ld) sampled_bit <= vote;
        end
    end

`ifdef UART_NOISE_FLAG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) noise_err <= 1'b0;
        else      noise_err <= vote_ld && (|vote_vec) && !(&vote_vec);
    end
`endif

endmodule

// File: doc/uart_oversampler.md
UART_OVERSAMPLER -- requirements
Module: uart_oversampler

Interface
REQ-001 SHALL have parameter PRESC_W, default 6, giving the Prescale and edge counter width.
REQ-002 SHALL have parameter SAMPLES, default 3, giving the odd vote count; legal values are 3, 5 and 7.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port RX_IN, input, 1 bit: serial line, already synchronised upstream.
REQ-006 SHALL have port data_samp_en, input, 1 bit: enables sampling; while high the bit-period counter runs.
REQ-007 SHALL have port Prescale, input, PRESC_W bits: oversampling ratio (clk cycles per bit).
REQ-008 SHALL have port edge_cnt, output, PRESC_W bits: current position within the bit period.
REQ-009 SHALL have port bit_done, output, 1 bit: 1-cycle pulse on the last cycle of each bit period.
REQ-010 SHALL have port sampled_bit, output, 1 bit: majority-voted bit value, held until the next vote.
REQ-011 SHALL have port bit_valid, output, 1 bit: 1-cycle pulse when sampled_bit updates.
REQ-012 SHALL have port cfg_err, output, 1 bit: latched Prescale is illegal.

Function
REQ-013 SHALL implement a 2-state FSM: IDLE and RUN.
- IDLE->RUN when data_samp_en=1.
- RUN->IDLE when data_samp_en=0.
REQ-014 SHALL latch Prescale into an internal register (pr) on the IDLE->RUN transition; Prescale changes during RUN have no effect.
REQ-015 SHALL treat pr as legal when pr >= SAMPLES+1 and pr is even; otherwise cfg_err=1 for the whole RUN, no sampling occurs and bit_valid stays 0.
REQ-016 In RUN, edge_cnt SHALL count 0..pr-1 and wrap to 0; the first RUN cycle has edge_cnt=0.
REQ-017 bit_done SHALL be high exactly when state=RUN and edge_cnt=pr-1.
REQ-018 SHALL use centre c=pr>>1 and half-window H=(SAMPLES-1)/2, capturing RX_IN at edge_cnt = c-H .. c+H (SAMPLES consecutive cycles).
REQ-019 The vote SHALL be 1 when more than SAMPLES/2 captured samples are 1; it is loaded into sampled_bit one cycle after the edge_cnt=c+H capture.
REQ-020 bit_valid SHALL pulse on the same cycle sampled_bit is loaded; latency from the last capture is exactly 1 clk.
REQ-021 Each bit period SHALL clear the sample store at edge_cnt=0 so no sample carries across bits.
REQ-022 When data_samp_en falls mid-period, edge_cnt and the sample store SHALL clear on the next edge, any pending vote is discarded, and sampled_bit holds its value.
REQ-023 If data_samp_en deasserts on the same cycle a vote would load, the vote SHALL be discarded and bit_valid stays 0.
REQ-024 In IDLE: edge_cnt=0, bit_done=0, bit_valid=0, cfg_err=0.

Reset
REQ-025 On rst=0 the block SHALL immediately force state=IDLE, edge_cnt=0, pr=0, sample store=0, sampled_bit=1 (line idle), bit_valid=0, bit_done=0 and cfg_err=0, including mid-operation.

Configuration
REQ-026 With UART_NOISE_FLAG_EN defined, the block SHALL add output noise_err (1 bit), pulsed together with bit_valid when the captured samples are not all equal.
REQ-027 Without UART_NOISE_FLAG_EN, the noise_err port and its logic SHALL be absent.

Structure
REQ-028 A shared package uart_pkg SHALL hold the FSM state typedef (IDLE, RUN) and the legal-SAMPLES constants.
REQ-029 The majority vote SHALL be a sub-module uart_majority_vote, parametrised by SAMPLES and purely combinational.
REQ-030 The top SHALL hold the FSM, counter, Prescale latch and sample store.

Verification
REQ-031 Prescale=8, SAMPLES=3, RX_IN=1 at edges 3 and 5, 0 at edge 4 -> sampled_bit=1 and bit_valid pulse at edge 6; bit_done at edge 7.
REQ-032 Prescale=16, SAMPLES=5, RX_IN=0 at edges 6-8 and 1 at edges 9-10 -> sampled_bit=0; noise_err=1 when UART_NOISE_FLAG_EN is defined.
REQ-033 Prescale=7 (odd) or Prescale=2 with SAMPLES=3 -> cfg_err=1, no bit_valid over 3 periods, and edge_cnt still wraps at pr-1.
REQ-034 Prescale 8->32 mid-RUN -> period stays 8 until an IDLE/RUN cycle; after re-entry bit_done every 32 clk and the vote is taken at edges 15-17.
REQ-035 data_samp_en dropped at edge 4 (Prescale=8) -> no bit_valid, edge_cnt=0 next cycle, sampled_bit unchanged.
REQ-036 rst asserted at edge 5 -> all outputs take their reset values asynchronously, and sampled_bit=1.
